// File: rtl/s_cpu_pkg.sv
// Shared constants for the Simple CPU v1 control path: opcodes, ALU selects,
// MUX B selects, decode classes and the control FSM state encoding.
package s_cpu_pkg;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_LDA  = 4'h1;
   localparam logic [3:0] OP_LDI  = 4'h2;
   localparam logic [3:0] OP_ADD  = 4'h3;
   localparam logic [3:0] OP_ADDI = 4'h4;
   localparam logic [3:0] OP_SUB  = 4'h5;
   localparam logic [3:0] OP_SUBI = 4'h6;
   localparam logic [3:0] OP_AND  = 4'h7;
   localparam logic [3:0] OP_ANDI = 4'h8;
   localparam logic [3:0] OP_STA  = 4'h9;
   localparam logic [3:0] OP_JMP  = 4'hA;
   localparam logic [3:0] OP_JZ   = 4'hB;
   localparam logic [3:0] OP_HLT  = 4'hF;

   localparam logic [1:0] ALU_PASSB = 2'b00;
   localparam logic [1:0] ALU_ADD   = 2'b01;
   localparam logic [1:0] ALU_SUB   = 2'b10;
   localparam logic [1:0] ALU_AND   = 2'b11;

   localparam logic MUXB_MEM = 1'b0;
   localparam logic MUXB_IR  = 1'b1;

   localparam logic [1:0] CLS_NONE = 2'd0;
   localparam logic [1:0] CLS_MEM  = 2'd1;
   localparam logic [1:0] CLS_IMM  = 2'd2;
   localparam logic [1:0] CLS_HALT = 2'd3;

   typedef enum logic [2:0] {
      ST_FETCH    = 3'd0,
      ST_DECODE   = 3'd1,
      ST_EXEC_MEM = 3'd2,
      ST_EXEC_IMM = 3'd3,
      ST_WB       = 3'd4,
      ST_HALT     = 3'd5
   } state_e;

endpackage

// File: rtl/s_cpu_decode.sv
// Combinational opcode decoder: instruction class, ALU op and store/jump flags.
module s_cpu_decode
   import s_cpu_pkg::*;
#(
   parameter int OPW  = 4,
   parameter int ALUW = 2
) (
   input  logic [OPW-1:0]  op,
   output logic [1:0]      cls,
   output logic [ALUW-1:0] alu_op,
   output logic            is_store,
   output logic            is_jump,
   output logic            is_cond
);

   // Unlisted opcodes fall through to the defaults, i.e. behave as NOP.
   always_comb begin
      cls      = CLS_NONE;
      alu_op   = ALU_PASSB;
      is_store = 1'b0;
      is_jump  = 1'b0;
      is_cond  = 1'b0;
      case (op)
         OP_LDA:  cls = CLS_MEM;
         OP_ADD:  begin cls = CLS_MEM; alu_op = ALU_ADD; end
         OP_SUB:  begin cls = CLS_MEM; alu_op = ALU_SUB; end
         OP_AND:  begin cls = CLS_MEM; alu_op = ALU_AND; end
         OP_STA:  begin cls = CLS_MEM; is_store = 1'b1; end
         OP_LDI:  cls = CLS_IMM;
         OP_ADDI: begin cls = CLS_IMM; alu_op = ALU_ADD; end
         OP_SUBI: begin cls = CLS_IMM; alu_op = ALU_SUB; end
         OP_ANDI: begin cls = CLS_IMM; alu_op = ALU_AND; end
         OP_JMP:  is_jump = 1'b1;
         OP_JZ:   begin is_jump = 1'b1; is_cond = 1'b1; end
         OP_HLT:  cls = CLS_HALT;
         default: cls = CLS_NONE;
      endcase
   end

endmodule

// File: rtl/s_cpu_ctrl.sv
// Multi-cycle fetch/decode/execute/writeback controller for Simple CPU v1.
// Optional S_CPU_CTRL_PERF_EN adds cycle and retired-instruction counters.
module s_cpu_ctrl
   import s_cpu_pkg::*;
#(
   parameter int OPW  = 4,
   parameter int ALUW = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [OPW-1:0]  ir_op,
   input  logic            acc_zero,
   input  logic            mem_ack,
   output logic            mem_req,
   output logic            mem_we,
   output logic            addr_sel,
   output logic            muxb,
   output logic            ir_ld,
   output logic            pc_inc,
   output logic            pc_ld,
   output logic            acc_ld,
   output logic [ALUW-1:0] alu_op,
   output logic            halted
`ifdef S_CPU_CTRL_PERF_EN
   ,
   output logic [15:0]     cyc_cnt,
   output logic [15:0]     ret_cnt
`endif
);

   state_e          state_q, state_d;
   logic [ALUW-1:0] opalu_q, opalu_d;
   logic            store_q, store_d;
   logic            mem_req_q, mem_we_q, addr_sel_q, muxb_q, acc_ld_q, halted_q;
   logic [ALUW-1:0] alu_q;

   logic [1:0]      dec_cls_s;
   logic [ALUW-1:0] dec_alu_s;
   logic            dec_store_s, dec_jump_s, dec_cond_s;
   logic            fetch_done_s;
   logic            exec_acc_s;

   s_cpu_decode #(.OPW(OPW), .ALUW(ALUW)) u_decode (
      .op       (ir_op),
      .cls      (dec_cls_s),
      .alu_op   (dec_alu_s),
      .is_store (dec_store_s),
      .is_jump  (dec_jump_s),
      .is_cond  (dec_cond_s)
   );

   // The fetch only completes once the registered request is actually out.
   assign fetch_done_s = (state_q == ST_FETCH) && mem_req_q && mem_ack;

   // Next-state logic; the instruction's ALU op and store flag are latched in DECODE.
   always_comb begin
      state_d = state_q;
      opalu_d = opalu_q;
      store_d = store_q;
      case (state_q)
         ST_FETCH: begin
            if (fetch_done_s) state_d = ST_DECODE;
            else              state_d = ST_FETCH;
         end
         ST_DECODE: begin
            opalu_d = dec_alu_s;
            store_d = dec_store_s;
            case (dec_cls_s)
               CLS_MEM:  state_d = ST_EXEC_MEM;
               CLS_IMM:  state_d = ST_EXEC_IMM;
               CLS_HALT: state_d = ST_HALT;
               default:  state_d = ST_FETCH;
            endcase
         end
         ST_EXEC_MEM: begin
            if (!mem_ack)     state_d = ST_EXEC_MEM;
            else if (store_q) state_d = ST_FETCH;
            else              state_d = ST_WB;
         end
         ST_EXEC_IMM: state_d = ST_FETCH;
         ST_WB:       state_d = ST_FETCH;
         ST_HALT:     state_d = ST_HALT;
         default:     state_d = ST_FETCH;
      endcase
   end

   assign exec_acc_s = (state_d == ST_EXEC_IMM) || (state_d == ST_WB);

   // State and output registers; outputs are derived from the next state so they track state_q.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_FETCH;
         opalu_q    <= ALU_PASSB;
         store_q    <= 1'b0;
         mem_req_q  <= 1'b0;
         mem_we_q   <= 1'b0;
         addr_sel_q <= 1'b0;
         muxb_q     <= MUXB_MEM;
         acc_ld_q   <= 1'b0;
         alu_q      <= ALU_PASSB;
         halted_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         opalu_q    <= opalu_d;
         store_q    <= store_d;
         mem_req_q  <= (state_d == ST_FETCH) || (state_d == ST_EXEC_MEM);
         mem_we_q   <= (state_d == ST_EXEC_MEM) && store_d;
         addr_sel_q <= (state_d == ST_EXEC_MEM);
         muxb_q     <= (state_d == ST_EXEC_IMM) ? MUXB_IR : MUXB_MEM;
         acc_ld_q   <= exec_acc_s;
         alu_q      <= exec_acc_s ? opalu_d : ALU_PASSB;
         halted_q   <= (state_d == ST_HALT);
      end
   end

   assign mem_req  = mem_req_q;
   assign mem_we   = mem_we_q;
   assign addr_sel = addr_sel_q;
   assign muxb     = muxb_q;
   assign acc_ld   = acc_ld_q;
   assign alu_op   = alu_q;
   assign halted   = halted_q;
   // Single-cycle strobes qualified by the registered state, so never both PC controls at once.
   assign ir_ld    = fetch_done_s;
   assign pc_inc   = fetch_done_s;
   assign pc_ld    = (state_q == ST_DECODE) && dec_jump_s && (!dec_cond_s || acc_zero);

`ifdef S_CPU_CTRL_PERF_EN
   logic [15:0] cyc_q, ret_q;
   logic        retire_s;

   assign retire_s = (state_d == ST_FETCH) && (state_q != ST_FETCH) && (state_q != ST_HALT);

   // Free-running counters that stop once the CPU halts; both wrap naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cyc_q <= 16'd0;
         ret_q <= 16'd0;
      end else begin
         if (state_q != ST_HALT) cyc_q <= cyc_q + 16'd1;
         if (retire_s)           ret_q <= ret_q + 16'd1;
      end
   end

   assign cyc_cnt = cyc_q;
   assign ret_cnt = ret_q;
`endif

endmodule

// File: tb/tb_s_cpu_ctrl.sv
// Directed self-checking bench for s_cpu_ctrl (perf counters checked when S_CPU_CTRL_PERF_EN is set).
module tb_s_cpu_ctrl;

   // Output vector: {mem_req, mem_we, addr_sel, muxb, ir_ld, pc_inc, pc_ld, acc_ld, alu_op[1:0], halted}
   localparam logic [10:0] O_IDLE = 11'b000_0000_0000;
   localparam logic [10:0] O_FREQ = 11'b100_0000_0000;
   localparam logic [10:0] O_FACK = 11'b100_0110_0000;
   localparam logic [10:0] O_EMRD = 11'b101_0000_0000;
   localparam logic [10:0] O_EMWR = 11'b111_0000_0000;
   localparam logic [10:0] O_PCLD = 11'b000_0001_0000;
   localparam logic [10:0] O_HALT = 11'b000_0000_0001;

   logic       clk;
   logic       rst_n;
   logic [3:0] ir_op;
   logic       acc_zero;
   logic       mem_ack;
   logic       mem_req, mem_we, addr_sel, muxb, ir_ld, pc_inc, pc_ld, acc_ld, halted;
   logic [1:0] alu_op;
   logic [10:0] outs;

   int checks;
   int failures;
   int ret_exp;

`ifdef S_CPU_CTRL_PERF_EN
   logic [15:0] cyc_cnt, ret_cnt;
   logic [15:0] tb_cyc;
   logic        tb_frozen;
`endif

   s_cpu_ctrl dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .ir_op    (ir_op),
      .acc_zero (acc_zero),
      .mem_ack  (mem_ack),
      .mem_req  (mem_req),
      .mem_we   (mem_we),
      .addr_sel (addr_sel),
      .muxb     (muxb),
      .ir_ld    (ir_ld),
      .pc_inc   (pc_inc),
      .pc_ld    (pc_ld),
      .acc_ld   (acc_ld),
      .alu_op   (alu_op),
      .halted   (halted)
`ifdef S_CPU_CTRL_PERF_EN
      ,
      .cyc_cnt  (cyc_cnt),
      .ret_cnt  (ret_cnt)
`endif
   );

   assign outs = {mem_req, mem_we, addr_sel, muxb, ir_ld, pc_inc, pc_ld, acc_ld, alu_op, halted};

   initial clk = 1'b0;
   always #5 clk = ~clk;

`ifdef S_CPU_CTRL_PERF_EN
   // Reference cycle count: every edge after reset until the bench marks HALT entry.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)          tb_cyc <= 16'd0;
      else if (!tb_frozen) tb_cyc <= tb_cyc + 16'd1;
   end
`endif

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #2;
      checks++;
      if (outs !== O_IDLE) begin failures++; $display("FAIL reset_hold outs=%b expected=%b", outs, O_IDLE); end
      #1 rst_n = 1'b1;
      #1;
      checks++;
      if (outs !== O_IDLE) begin failures++; $display("FAIL reset_release outs=%b expected=%b", outs, O_IDLE); end
      @(posedge clk); #2;
      checks++;
      if (outs !== O_FREQ) begin failures++; $display("FAIL reset_first_req outs=%b expected=%b", outs, O_FREQ); end
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if (outs !== O_IDLE) begin failures++; $display("FAIL reset_async_drop outs=%b expected=%b", outs, O_IDLE); end
      #1 rst_n = 1'b1;
      ret_exp = 0;
      @(posedge clk); #2;
      checks++;
      if (outs !== O_FREQ) begin failures++; $display("FAIL reset_refetch outs=%b expected=%b", outs, O_FREQ); end
   endtask

   task automatic test_ldi_wait();
      logic        ack_v [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      logic [10:0] exp_v [7] = '{O_FREQ, O_FREQ, O_FREQ, O_FACK, O_IDLE, 11'b000_1000_1000, O_FREQ};
      ir_op = 4'h2; acc_zero = 1'b0;
      for (int i = 0; i < 7; i++) begin
         mem_ack = ack_v[i]; #1;
         checks++;
         if (outs !== exp_v[i]) begin failures++; $display("FAIL ldi_wait cyc%0d outs=%b expected=%b", i, outs, exp_v[i]); end
         @(posedge clk); #2;
      end
      ret_exp++;
   endtask

   task automatic test_add();
      logic        ack_v [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      logic [10:0] exp_v [5] = '{O_FACK, O_IDLE, O_EMRD, 11'b000_0000_1010, O_FREQ};
      ir_op = 4'h3;
      for (int i = 0; i < 5; i++) begin
         mem_ack = ack_v[i]; #1;
         checks++;
         if (outs !== exp_v[i]) begin failures++; $display("FAIL add cyc%0d outs=%b expected=%b", i, outs, exp_v[i]); end
         @(posedge clk); #2;
      end
      ret_exp++;
   endtask

   task automatic test_sta_wait();
      logic        ack_v [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      logic [10:0] exp_v [6] = '{O_FACK, O_IDLE, O_EMWR, O_EMWR, O_EMWR, O_FREQ};
      ir_op = 4'h9;
      for (int i = 0; i < 6; i++) begin
         mem_ack = ack_v[i]; #1;
         checks++;
         if (outs !== exp_v[i]) begin failures++; $display("FAIL sta_wait cyc%0d outs=%b expected=%b", i, outs, exp_v[i]); end
         @(posedge clk); #2;
      end
      ret_exp++;
   endtask

   task automatic test_jump();
      logic [3:0] op_v  [5] = '{4'hB, 4'hB, 4'hA, 4'h0, 4'hC};
      logic       az_v  [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      logic       pcl_v [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      logic [10:0] exp_s;
      for (int r = 0; r < 5; r++) begin
         ir_op = op_v[r]; acc_zero = az_v[r];
         for (int i = 0; i < 3; i++) begin
            mem_ack = (i == 0) ? 1'b1 : 1'b0;
            exp_s = (i == 0) ? O_FACK : (i == 1) ? (pcl_v[r] ? O_PCLD : O_IDLE) : O_FREQ;
            #1;
            checks++;
            if (outs !== exp_s) begin failures++; $display("FAIL jump op%h cyc%0d outs=%b expected=%b", op_v[r], i, outs, exp_s); end
            @(posedge clk); #2;
         end
         ret_exp++;
      end
   endtask

   task automatic test_alu_ops();
      logic [3:0] op_v  [6] = '{4'h1, 4'h5, 4'h7, 4'h4, 4'h6, 4'h8};
      logic       mem_v [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      logic [1:0] alu_v [6] = '{2'b00, 2'b10, 2'b11, 2'b01, 2'b10, 2'b11};
      logic [10:0] exp_s;
      int          n;
      for (int r = 0; r < 6; r++) begin
         ir_op = op_v[r];
         n = mem_v[r] ? 5 : 4;
         for (int i = 0; i < n; i++) begin
            mem_ack = (i == 0 || (mem_v[r] && i == 2)) ? 1'b1 : 1'b0;
            if (i == 0)                 exp_s = O_FACK;
            else if (i == 1)            exp_s = O_IDLE;
            else if (i == n - 1)        exp_s = O_FREQ;
            else if (mem_v[r] && i == 2) exp_s = O_EMRD;
            else if (mem_v[r])          exp_s = {8'b0000_0001, alu_v[r], 1'b0};
            else                        exp_s = {8'b0001_0001, alu_v[r], 1'b0};
            #1;
            checks++;
            if (outs !== exp_s) begin failures++; $display("FAIL alu op%h cyc%0d outs=%b expected=%b", op_v[r], i, outs, exp_s); end
            @(posedge clk); #2;
         end
         ret_exp++;
      end
   endtask

   task automatic test_halt();
      logic        ack_v [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      logic [10:0] exp_v [8] = '{O_FACK, O_IDLE, O_HALT, O_HALT, O_HALT, O_HALT, O_HALT, O_HALT};
      ir_op = 4'hF;
      for (int i = 0; i < 8; i++) begin
         mem_ack = ack_v[i]; #1;
         checks++;
         if (outs !== exp_v[i]) begin failures++; $display("FAIL halt cyc%0d outs=%b expected=%b", i, outs, exp_v[i]); end
         @(posedge clk); #2;
`ifdef S_CPU_CTRL_PERF_EN
         if (i == 1) tb_frozen = 1'b1;
`endif
      end
`ifdef S_CPU_CTRL_PERF_EN
      checks++;
      if (cyc_cnt !== tb_cyc) begin failures++; $display("FAIL halt_cyc_cnt got=%0d expected=%0d", cyc_cnt, tb_cyc); end
      checks++;
      if (ret_cnt !== ret_exp[15:0]) begin failures++; $display("FAIL halt_ret_cnt got=%0d expected=%0d", ret_cnt, ret_exp); end
`endif
      mem_ack = 1'b0;
      rst_n = 1'b0; #1;
      checks++;
      if (outs !== O_IDLE) begin failures++; $display("FAIL halt_reset_exit outs=%b expected=%b", outs, O_IDLE); end
      rst_n = 1'b1;
   endtask

   initial begin
      checks = 0; failures = 0; ret_exp = 0;
      rst_n = 1'b0; ir_op = 4'h0; acc_zero = 1'b0; mem_ack = 1'b0;
`ifdef S_CPU_CTRL_PERF_EN
      tb_frozen = 1'b0;
`endif
      test_reset();
      test_ldi_wait();
      test_add();
      test_sta_wait();
      test_jump();
      test_alu_ops();
      test_halt();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
